// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings and default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are staged in pending
// registers and committed when the countdown expires.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = MDU_WIDTH,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             md_use_d,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    logic             accept;
    logic             accept_arith;
    logic             is_div;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] divisor;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [CNT_W-1:0] load_cnt;

    assign accept       = start && !busy_q;
    assign accept_arith = accept && is_md_arith(md_op);
    assign is_div       = (md_op == 3'(MD_DIV)) || (md_op == 3'(MD_DIVU));
    assign div_zero     = (rt == '0);
    assign divisor      = div_zero ? WIDTH'(1) : rt;
    assign div_ovf      = (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == '1);

    // Product/quotient datapath, only meaningful on the accepting edge.
    always_comb begin
        prod     = '0;
        quo      = '0;
        rem      = '0;
        load_cnt = CNT_W'(MULT_CYCLES);
        case (md_op)
            3'(MD_MULT):  prod = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
            3'(MD_MULTU): prod = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
            3'(MD_DIV): begin
                load_cnt = CNT_W'(DIV_CYCLES);
                // Most-negative / -1 overflows; define it as quotient=dividend, remainder=0.
                if (div_ovf) begin
                    quo = rs;
                    rem = '0;
                end else begin
                    quo = WIDTH'($signed(rs) / $signed(divisor));
                    rem = WIDTH'($signed(rs) % $signed(divisor));
                end
            end
            3'(MD_DIVU): begin
                load_cnt = CNT_W'(DIV_CYCLES);
                quo      = rs / divisor;
                rem      = rs % divisor;
            end
            default: ;
        endcase
        res_hi = is_div ? rem : prod[DW-1:WIDTH];
        res_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    // Countdown, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            busy_q  <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept_arith) begin
                cnt     <= load_cnt;
                busy_q  <= 1'b1;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !(is_div && div_zero);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    if (pend_wr) begin
                        hi <= pend_hi;
                        lo <= pend_lo;
                    end
                end
            end
            if (accept && (md_op == 3'(MD_MTHI))) hi <= rs;
            if (accept && (md_op == 3'(MD_MTLO))) lo <= rs;
        end
    end

    assign busy      = busy_q;
    assign stall_req = (busy_q || (start && is_md_arith(md_op))) && md_use_d;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with default parameters.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt;
    int total_cnt;

    mdu_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs       (rs),
        .rt       (rt),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for exactly one rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'd0;
        rs    = 32'hDEAD_BEEF;
        rt    = 32'hCAFE_F00D;
    endtask

    // Count busy cycles; returns at the first negedge where busy is low.
    task automatic wait_done(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        md_use_d = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi got=%h exp=0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo got=%h exp=0", lo); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (stall_req !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_req); else pass_cnt++;
        md_use_d = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        total_cnt++; if (n != 5) $display("FAIL mult_cycles got=%0d exp=5", n); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got=%h exp=ffffffff", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo got=%h exp=fffffffa", lo); else pass_cnt++;
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_done(n);
        total_cnt++; if (n != 5) $display("FAIL multu_cycles got=%0d exp=5", n); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0000_0002) $display("FAIL multu_hi got=%h exp=00000002", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFFA) $display("FAIL multu_lo got=%h exp=fffffffa", lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int n;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        total_cnt++; if (n != 10) $display("FAIL div_cycles got=%0d exp=10", n); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", hi); else pass_cnt++;
        issue(3'd4, 32'd7, 32'd2);
        wait_done(n);
        total_cnt++; if (n != 10) $display("FAIL divu_cycles got=%0d exp=10", n); else pass_cnt++;
        total_cnt++; if (lo !== 32'd3) $display("FAIL divu_lo got=%h exp=00000003", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd1) $display("FAIL divu_hi got=%h exp=00000001", hi); else pass_cnt++;
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        total_cnt++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got=%h exp=80000000", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL div_ovf_hi got=%h exp=00000000", hi); else pass_cnt++;
    endtask

    task automatic test_divzero();
        int n;
        issue(3'd5, 32'h11, 32'h0);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'h11) $display("FAIL mthi_hi got=%h exp=00000011", hi); else pass_cnt++;
        issue(3'd6, 32'h22, 32'h0);
        @(negedge clk);
        total_cnt++; if (lo !== 32'h22) $display("FAIL mtlo_lo got=%h exp=00000022", lo); else pass_cnt++;
        issue(3'd3, 32'd5, 32'd0);
        wait_done(n);
        total_cnt++; if (n != 10) $display("FAIL divz_cycles got=%0d exp=10", n); else pass_cnt++;
        total_cnt++; if (hi !== 32'h11) $display("FAIL divz_hi got=%h exp=00000011", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h22) $display("FAIL divz_lo got=%h exp=00000022", lo); else pass_cnt++;
    endtask

    task automatic test_noop();
        issue(3'd0, 32'h55, 32'h66);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL none_busy got=%b exp=0", busy); else pass_cnt++;
        issue(3'd7, 32'h55, 32'h66);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rsvd_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'h11 || lo !== 32'h22)
            $display("FAIL noop_hilo got=%h/%h exp=00000011/00000022", hi, lo); else pass_cnt++;
    endtask

    task automatic test_stall_back_to_back();
        int n;
        md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b1; md_op = 3'd1; rs = 32'd5; rt = 32'd6;
        #1;
        total_cnt++; if (stall_req !== 1'b1) $display("FAIL stall_start got=%b exp=1", stall_req); else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'd0; rs = 32'd1000; rt = 32'd1000;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            total_cnt++; if (stall_req !== 1'b1) $display("FAIL stall_busy%0d got=%b exp=1", n, stall_req); else pass_cnt++;
            if (n == 2) begin
                start = 1'b1; md_op = 3'd3; rs = 32'd100; rt = 32'd7;
                @(posedge clk);
                #1;
                start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
        end
        total_cnt++; if (n != 5) $display("FAIL b2b_cycles got=%0d exp=5", n); else pass_cnt++;
        total_cnt++; if (stall_req !== 1'b0) $display("FAIL stall_drop got=%b exp=0", stall_req); else pass_cnt++;
        total_cnt++; if (lo !== 32'd30) $display("FAIL b2b_lo got=%h exp=0000001e", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL b2b_hi got=%h exp=00000000", hi); else pass_cnt++;
        repeat (12) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || lo !== 32'd30)
            $display("FAIL b2b_settle got=busy%b lo=%h exp=busy0 lo=0000001e", busy, lo); else pass_cnt++;
        md_use_d = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(3'd1, 32'd7, 32'd9);
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0 || lo !== 32'h0)
            $display("FAIL mid_rst_hilo got=%h/%h exp=0/0", hi, lo); else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0)
            $display("FAIL late_commit got=%h/%h busy%b exp=0/0 busy0", hi, lo, busy); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        start     = 1'b0;
        md_op     = 3'd0;
        rs        = 32'h0;
        rt        = 32'h0;
        md_use_d  = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_noop();
        test_stall_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
